// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron node: default widths, default leak
// shift, the synaptic weight type and its reset value.
// Build macro: SYN_INHIB_EN selects signed (inhibitory-capable) weights.
package lif_pkg;

   localparam int LIF_N_SYN       = 4;
   localparam int LIF_W_W         = 4;
   localparam int LIF_CUR_W       = 8;
   localparam int LIF_DECAY_SHIFT = 3;

`ifdef SYN_INHIB_EN
   typedef logic signed [LIF_W_W-1:0] syn_w_t;
`else
   typedef logic [LIF_W_W-1:0] syn_w_t;
`endif

   localparam syn_w_t SYN_W_RST = syn_w_t'(1);

endpackage

// File: rtl/syn_weight_bank.sv
// Per-synapse weight register file. One write port, all weights read out
// flat so the adder in the top level can see every synapse at once.
module syn_weight_bank
   import lif_pkg::*;
#(
   parameter int N_SYN = LIF_N_SYN,
   parameter int W_W   = LIF_W_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   w_load,
   input  logic [1:0]             w_sel,
   input  logic [W_W-1:0]         w_data,
   output logic [N_SYN*W_W-1:0]   o_w_flat
);

   localparam logic [W_W-1:0] W_RST = W_W'(SYN_W_RST);

   logic [W_W-1:0] r_w [N_SYN];

   // Weight storage: reset to +1, write the selected entry on w_load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_SYN; k++) begin
            r_w[k] <= W_RST;
         end
      end else if (w_load) begin
         for (int k = 0; k < N_SYN; k++) begin
            if (w_sel == 2'(k)) begin
               r_w[k] <= w_data;
            end
         end
      end
   end

   for (genvar g = 0; g < N_SYN; g++) begin : g_flat
      assign o_w_flat[g*W_W +: W_W] = r_w[g];
   end

endmodule

// File: rtl/lif_synapse_drive.sv
// Synaptic front end of the LIF node: rising-edge detect on each spike line,
// weighted sum of edges, exponential leak with a floor of 1, clamp, and an
// accepted-edge counter.
// Build macro: SYN_INHIB_EN enables signed weights and the clamp at zero.
module lif_synapse_drive
   import lif_pkg::*;
#(
   parameter int N_SYN       = LIF_N_SYN,
   parameter int W_W         = LIF_W_W,
   parameter int CUR_W       = LIF_CUR_W,
   parameter int DECAY_SHIFT = LIF_DECAY_SHIFT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_SYN-1:0]  spike_in,
   input  logic              w_load,
   input  logic [1:0]        w_sel,
   input  logic [W_W-1:0]    w_data,
   input  logic              hold,
   output logic [CUR_W-1:0]  current,
   output logic              sat,
   output logic [7:0]        ev_cnt
);

   // Two guard bits cover both the 255 + 60 overshoot and a negative result.
   localparam int SW = CUR_W + 2;
   localparam logic signed [SW-1:0] C_MAX = SW'((1 << CUR_W) - 1);

   logic [N_SYN-1:0]        r_spike_q;
   logic [CUR_W-1:0]        r_cur;
   logic                    r_sat;
   logic [7:0]              r_ev;

   logic [N_SYN*W_W-1:0]    w_w_flat;
   logic [N_SYN-1:0]        w_edge;
   logic [7:0]              w_edge_cnt;
   logic signed [SW-1:0]    w_sum;
   logic [CUR_W-1:0]        w_leak_raw;
   logic [CUR_W-1:0]        w_leak_fl;
   logic signed [SW-1:0]    w_cur_ext;
   logic signed [SW-1:0]    w_leak;
   logic signed [SW-1:0]    w_next;
   logic [CUR_W-1:0]        w_cur_d;
   logic                    w_sat_d;

   syn_weight_bank #(
      .N_SYN (N_SYN),
      .W_W   (W_W)
   ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_load   (w_load),
      .w_sel    (w_sel),
      .w_data   (w_data),
      .o_w_flat (w_w_flat)
   );

   assign w_edge = spike_in & ~r_spike_q;

   // Weighted sum of this cycle's edges and the number of edges.
   always_comb begin
      w_sum      = '0;
      w_edge_cnt = '0;
      for (int k = 0; k < N_SYN; k++) begin
         if (w_edge[k]) begin
`ifdef SYN_INHIB_EN
            w_sum = w_sum + {{(SW-W_W){w_w_flat[k*W_W+W_W-1]}}, w_w_flat[k*W_W +: W_W]};
`else
            w_sum = w_sum + {{(SW-W_W){1'b0}}, w_w_flat[k*W_W +: W_W]};
`endif
            w_edge_cnt = w_edge_cnt + 8'd1;
         end
      end
   end

   // Leak with a floor of 1 so a small non-zero current always reaches 0.
   always_comb begin
      w_leak_raw = r_cur >> DECAY_SHIFT;
      w_leak_fl  = w_leak_raw;
      if ((r_cur != '0) && (w_leak_raw == '0)) begin
         w_leak_fl = CUR_W'(1);
      end
   end

   assign w_cur_ext = {2'b00, r_cur};
   assign w_leak    = {2'b00, w_leak_fl};
   assign w_next    = w_cur_ext - w_leak + w_sum;

   // Clamp the candidate current and flag any clipping.
   always_comb begin
      w_cur_d = w_next[CUR_W-1:0];
      w_sat_d = 1'b0;
      if (w_next > C_MAX) begin
         w_cur_d = '1;
         w_sat_d = 1'b1;
      end
`ifdef SYN_INHIB_EN
      else if (w_next < 0) begin
         w_cur_d = '0;
         w_sat_d = 1'b1;
      end
`endif
   end

   // State update: edge history always tracks, the rest freezes under hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spike_q <= '0;
         r_cur     <= '0;
         r_sat     <= 1'b0;
         r_ev      <= '0;
      end else begin
         r_spike_q <= spike_in;
         if (!hold) begin
            r_cur <= w_cur_d;
            r_sat <= w_sat_d;
            r_ev  <= r_ev + w_edge_cnt;
         end
      end
   end

   assign current = r_cur;
   assign sat     = r_sat;
   assign ev_cnt  = r_ev;

endmodule

// File: tb/tb_lif_synapse_drive.sv
// Directed bench for lif_synapse_drive. Inputs change 1 ns after the rising
// edge and outputs are sampled there too, well clear of the next edge.
module tb_lif_synapse_drive;

   logic       clk;
   logic       rst_n;
   logic [3:0] spike_in;
   logic       w_load;
   logic [1:0] w_sel;
   logic [3:0] w_data;
   logic       hold;
   logic [7:0] current;
   logic       sat;
   logic [7:0] ev_cnt;

   int total = 0;
   int bad   = 0;

   lif_synapse_drive dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spike_in (spike_in),
      .w_load   (w_load),
      .w_sel    (w_sel),
      .w_data   (w_data),
      .hold     (hold),
      .current  (current),
      .sat      (sat),
      .ev_cnt   (ev_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] sel, input logic [3:0] data);
      w_load = 1'b1;
      w_sel  = sel;
      w_data = data;
      tick();
      w_load = 1'b0;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      spike_in = 4'b0000;
      w_load   = 1'b0;
      w_sel    = 2'd0;
      w_data   = 4'd0;
      hold     = 1'b0;
      #3;
      chk("rst_current", current, 0);
      chk("rst_sat", sat, 0);
      chk("rst_ev", ev_cnt, 0);
      #9 rst_n = 1'b1;
      tick();

      // single rise with reset weight 1, then leak floor
      spike_in = 4'b0001;
      tick();
      chk("rise_current", current, 1);
      chk("rise_ev", ev_cnt, 1);
      chk("rise_sat", sat, 0);
      tick();
      chk("leak_floor", current, 0);

      // four-way burst with weights 15
      spike_in = 4'b0000;
      load(2'd0, 4'd15);
      load(2'd1, 4'd15);
      load(2'd2, 4'd15);
      load(2'd3, 4'd15);
      spike_in = 4'b1111;
      tick();
      chk("burst_60", current, 60);
      chk("burst_ev", ev_cnt, 5);
      spike_in = 4'b0000;
      tick();
      chk("burst_53", current, 53);
      tick();
      chk("burst_47", current, 47);
      repeat (60) tick();
      chk("decay_zero", current, 0);

      // saturation: 63 bursts; ev_cnt wraps 5 + 252 = 257 -> 1
      repeat (62) begin
         spike_in = 4'b1111;
         tick();
         spike_in = 4'b0000;
         tick();
      end
      spike_in = 4'b1111;
      tick();
      chk("sat_current", current, 255);
      chk("sat_flag", sat, 1);
      chk("ev_wrap", ev_cnt, 1);
      spike_in = 4'b0000;
      tick();
      chk("unsat_current", current, 224);
      chk("unsat_flag", sat, 0);

      // asynchronous reset mid-operation, no clock edge involved
      rst_n = 1'b0;
      #2;
      chk("arst_current", current, 0);
      chk("arst_sat", sat, 0);
      chk("arst_ev", ev_cnt, 0);
      spike_in = 4'b0100;
      #2 rst_n = 1'b1;
      tick();
      chk("high_at_release", current, 1);
      chk("high_at_release_ev", ev_cnt, 1);
      repeat (9) tick();
      chk("level_held_current", current, 0);
      chk("level_held_ev", ev_cnt, 1);

      // weight write in the same cycle as an edge uses the old weight
      spike_in = 4'b0110;
      w_load   = 1'b1;
      w_sel    = 2'd1;
      w_data   = 4'd9;
      tick();
      w_load   = 1'b0;
      chk("same_cycle_old_w", current, 1);
      chk("same_cycle_ev", ev_cnt, 2);
      spike_in = 4'b0100;
      tick();
      chk("same_cycle_decay", current, 0);
      spike_in = 4'b0110;
      tick();
      chk("new_w_used", current, 9);
      chk("new_w_ev", ev_cnt, 3);

      // hold freezes current and drops edges; load during hold still lands
      spike_in = 4'b0000;
      repeat (20) tick();
      chk("pre_hold_zero", current, 0);
      load(2'd0, 4'd15);
      load(2'd1, 4'd15);
      load(2'd2, 4'd10);
      spike_in = 4'b0111;
      tick();
      chk("pre_hold_40", current, 40);
      chk("pre_hold_ev", ev_cnt, 6);
      hold     = 1'b1;
      spike_in = 4'b1111;
      w_load   = 1'b1;
      w_sel    = 2'd3;
      w_data   = 4'd2;
      tick();
      w_load   = 1'b0;
      chk("hold_current", current, 40);
      chk("hold_ev", ev_cnt, 6);
      chk("hold_sat", sat, 0);
      hold = 1'b0;
      tick();
      chk("release_35", current, 35);
      chk("release_ev", ev_cnt, 6);
      spike_in = 4'b0000;
      tick();
      chk("release_31", current, 31);
      spike_in = 4'b1000;
      tick();
      chk("hold_loaded_w", current, 30);
      chk("hold_loaded_ev", ev_cnt, 7);

      // weight code 4'b1000: -8 with inhibition, +8 without
      spike_in = 4'b0000;
      repeat (40) tick();
      load(2'd1, 4'd5);
      load(2'd0, 4'b1000);
      spike_in = 4'b0010;
      tick();
      chk("inh_pre_5", current, 5);
      spike_in = 4'b0011;
      tick();
`ifdef SYN_INHIB_EN
      chk("inh_clamp_zero", current, 0);
      chk("inh_sat", sat, 1);
`else
      chk("w8_unsigned", current, 12);
      chk("w8_sat", sat, 0);
`endif
      chk("inh_ev", ev_cnt, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
